// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM state encoding
// and default sizing for the address and dwell counter.
package decoder_scan_sequencer_pkg;

    localparam int N_DEF       = 3;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

endpackage : decoder_scan_sequencer_pkg

// File: rtl/decoder_scan_sequencer_dwell_timer.sv
// Dwell timer: down-counter loaded with the dwell length when an ON window
// opens; o_expire marks the last cycle of that window (terminal count 1).
module decoder_scan_sequencer_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    input  logic               i_clear,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_cnt;

    // Abort clears, a new window reloads, otherwise count down and rest at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
        end
    end

    assign o_expire = (r_cnt == DWELL_W'(1));

endmodule : decoder_scan_sequencer_dwell_timer

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer feeding decoder_nbit: steps the address 0..2**N-1, holding
// each for D enable-high cycles, with a single blanking cycle in between so
// the decoded one-hot lines break before they make.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; a=0, enable=0
//   ST_ON    | address driven, enable high for D cycles
//   ST_BLANK | one cycle enable low before the address advances
module decoder_scan_sequencer
    import decoder_scan_sequencer_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_continuous,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [N-1:0]       o_a,
    output logic               o_enable,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_scan_wrap
);

    localparam logic [N-1:0] A_LAST = '1;

    state_t             r_state;
    logic [N-1:0]       r_a;
    logic               r_enable;
    logic               r_busy;
    logic               r_done;
    logic               r_scan_wrap;
    logic [DWELL_W-1:0] r_dwell_lat;
    logic               r_cont_lat;

    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_start_ok;
    logic               w_abort;
    logic               w_load;
    logic [DWELL_W-1:0] w_load_val;
    logic               w_expire;

    // A programmed dwell of zero still gives a one-cycle ON window.
    assign w_dwell_eff = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
    assign w_start_ok  = (r_state == ST_IDLE) && i_start && !i_stop;
    assign w_abort     = (r_state != ST_IDLE) && i_stop;
    // The timer loads straight from the input on start, since the latch
    // only takes the value on that same edge.
    assign w_load      = w_start_ok || ((r_state == ST_BLANK) && !i_stop);
    assign w_load_val  = (r_state == ST_IDLE) ? w_dwell_eff : r_dwell_lat;

    decoder_scan_sequencer_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .i_clk      (i_clk),
        .i_rst      (i_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_clear    (w_abort),
        .o_expire   (w_expire)
    );

    // Scan FSM with registered address, enable, busy and one-cycle pulses.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_enable    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_scan_wrap <= 1'b0;
            r_dwell_lat <= '0;
            r_cont_lat  <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_scan_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_dwell_lat <= w_dwell_eff;
                        r_cont_lat  <= i_continuous;
                        r_a         <= '0;
                        r_enable    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ON;
                    end
                end
                ST_ON: begin
                    if (i_stop) begin
                        r_a      <= '0;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (w_expire) begin
                        if (r_a != A_LAST) begin
                            r_enable <= 1'b0;
                            r_state  <= ST_BLANK;
                        end else if (r_cont_lat) begin
                            r_enable    <= 1'b0;
                            r_scan_wrap <= 1'b1;
                            r_state     <= ST_BLANK;
                        end else begin
                            r_a      <= '0;
                            r_enable <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                ST_BLANK: begin
                    if (i_stop) begin
                        r_a      <= '0;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_a      <= r_a + N'(1);
                        r_enable <= 1'b1;
                        r_state  <= ST_ON;
                    end
                end
                default: begin
                    r_a      <= '0;
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_a         = r_a;
    assign o_enable    = r_enable;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_scan_wrap = r_scan_wrap;

endmodule : decoder_scan_sequencer
